ifu_fetch_redirect: RTL and testbench

//  Fetch-side consumer of the EXU branch unit's registered redirect (jump_flag/jump_addr).

---
 rtl/ifu_fetch_redirect.sv | 138 +++++++++++++
 tb/tb_ifu_fetch_redirect.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_redirect.sv
// Fetch-side PC owner: issues in-order word fetches under a credit limit, buffers responses for
// decode and discards wrong-path responses after an EXU redirect.
module ifu_fetch_redirect #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned FIFO_DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic        ifu_req_valid_o,
    output logic [31:0] ifu_req_addr_o,
    input  logic        ifu_req_ready_i,
    input  logic        ifu_rsp_valid_i,
    input  logic [31:0] ifu_rsp_data_i,
    input  logic        ifu_rsp_err_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_err_o,
    input  logic        inst_ready_i
);

    localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned AQW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned FPW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   kill_q, kill_d;
    logic [AQW-1:0]  aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;
    logic [FPW-1:0]  f_wr_q, f_wr_d, f_rd_q, f_rd_d;
    logic [FCW-1:0]  f_cnt_q, f_cnt_d;

    logic [31:0] aq_mem [MAX_OUTSTANDING];
    logic [31:0] f_pc   [FIFO_DEPTH];
    logic [31:0] f_data [FIFO_DEPTH];
    logic        f_err  [FIFO_DEPTH];

    logic        req_fire, rsp_kill, push, pop;
    logic [31:0] outst_ext, fcnt_ext;

    function automatic logic [AQW-1:0] aq_inc(input logic [AQW-1:0] p);
        return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + AQW'(1);
    endfunction

    function automatic logic [FPW-1:0] f_inc(input logic [FPW-1:0] p);
        return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + FPW'(1);
    endfunction

    assign outst_ext = 32'(outst_q);
    assign fcnt_ext  = 32'(f_cnt_q);

    // Credit rule: every accepted request is guaranteed a FIFO slot for its response.
    assign ifu_req_valid_o = (state_q == StRun) & ~jump_flag_i
                           & (outst_ext < MAX_OUTSTANDING)
                           & (outst_ext + fcnt_ext < FIFO_DEPTH);
    assign ifu_req_addr_o  = pc_q;
    assign req_fire        = ifu_req_valid_o & ifu_req_ready_i;

    assign rsp_kill     = (kill_q != '0) | jump_flag_i;
    assign push         = ifu_rsp_valid_i & ~rsp_kill;
    assign inst_valid_o = (f_cnt_q != '0) & ~jump_flag_i;
    assign pop          = inst_valid_o & inst_ready_i;
    assign inst_o       = f_data[f_rd_q];
    assign inst_pc_o    = f_pc[f_rd_q];
    assign inst_err_o   = f_err[f_rd_q];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        outst_d = outst_q - CW'(ifu_rsp_valid_i) + CW'(req_fire);
        kill_d  = kill_q;
        aq_wr_d = req_fire ? aq_inc(aq_wr_q) : aq_wr_q;
        aq_rd_d = ifu_rsp_valid_i ? aq_inc(aq_rd_q) : aq_rd_q;
        f_wr_d  = push ? f_inc(f_wr_q) : f_wr_q;
        f_rd_d  = pop ? f_inc(f_rd_q) : f_rd_q;
        f_cnt_d = f_cnt_q + FCW'(push) - FCW'(pop);

        if (ifu_rsp_valid_i && (kill_q != '0)) kill_d = kill_q - CW'(1);
        if (push && ifu_rsp_err_i) state_d = StHalt;
        if (req_fire) pc_d = pc_q + 32'd4;

        // Redirect: everything still in flight is wrong-path; the kill count is recomputed.
        if (jump_flag_i) begin
            pc_d    = {jump_addr_i[31:2], 2'b00};
            state_d = StRun;
            kill_d  = outst_q - CW'(ifu_rsp_valid_i);
            f_wr_d  = '0;
            f_rd_d  = '0;
            f_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            outst_q <= '0;
            kill_q  <= '0;
            aq_wr_q <= '0;
            aq_rd_q <= '0;
            f_wr_q  <= '0;
            f_rd_q  <= '0;
            f_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            outst_q <= outst_d;
            kill_q  <= kill_d;
            aq_wr_q <= aq_wr_d;
            aq_rd_q <= aq_rd_d;
            f_wr_q  <= f_wr_d;
            f_rd_q  <= f_rd_d;
            f_cnt_q <= f_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) aq_mem[aq_wr_q] <= pc_q;
        if (push) begin
            f_pc[f_wr_q]   <= aq_mem[aq_rd_q];
            f_data[f_wr_q] <= ifu_rsp_data_i;
            f_err[f_wr_q]  <= ifu_rsp_err_i;
        end
    end

    a_rsp_has_req: assert property (@(posedge clk) disable iff (rst)
        ifu_rsp_valid_i |-> (outst_q != '0));
    a_kill_le_outst: assert property (@(posedge clk) disable iff (rst)
        kill_q <= outst_q);

endmodule

// File: tb/tb_ifu_fetch_redirect.sv
// Randomized bench for ifu_fetch_redirect against a queue-based model of in-flight fetches
// (each tagged stale or live) and the decode buffer.
module tb_ifu_fetch_redirect;

    localparam int unsigned MAXO = 2;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk, rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        ifu_req_valid_o;
    logic [31:0] ifu_req_addr_o;
    logic        ifu_req_ready_i;
    logic        ifu_rsp_valid_i;
    logic [31:0] ifu_rsp_data_i;
    logic        ifu_rsp_err_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_err_o;
    logic        inst_ready_i;

    ifu_fetch_redirect #(
        .RESET_PC        (RPC),
        .MAX_OUTSTANDING (MAXO),
        .FIFO_DEPTH      (DEPTH)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .jump_flag_i     (jump_flag_i),
        .jump_addr_i     (jump_addr_i),
        .ifu_req_valid_o (ifu_req_valid_o),
        .ifu_req_addr_o  (ifu_req_addr_o),
        .ifu_req_ready_i (ifu_req_ready_i),
        .ifu_rsp_valid_i (ifu_rsp_valid_i),
        .ifu_rsp_data_i  (ifu_rsp_data_i),
        .ifu_rsp_err_i   (ifu_rsp_err_i),
        .inst_valid_o    (inst_valid_o),
        .inst_o          (inst_o),
        .inst_pc_o       (inst_pc_o),
        .inst_err_o      (inst_err_o),
        .inst_ready_i    (inst_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } fl_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        err;
    } ent_t;

    fl_t         inflight[$];
    ent_t        fifo[$];
    logic [31:0] m_pc;
    bit          m_halt;
    int          checks = 0;
    int          errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic drive_idle();
        jump_flag_i     = 1'b0;
        jump_addr_i     = '0;
        ifu_req_ready_i = 1'b0;
        ifu_rsp_valid_i = 1'b0;
        ifu_rsp_data_i  = '0;
        ifu_rsp_err_i   = 1'b0;
        inst_ready_i    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        #1;
        check_eq("rst_inst_valid", 32'(inst_valid_o), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        inflight.delete();
        fifo.delete();
        m_pc   = RPC;
        m_halt = 1'b0;
    endtask

    // One clock: drive at negedge, check combinational outputs, advance the model.
    task automatic cycle(input bit jmp, input logic [31:0] ja, input bit rdy, input bit ird,
                         input bit rsp_want, input bit er);
        bit   rsp, exp_rv, exp_iv, fire, pop;
        fl_t  e;
        ent_t ne;
        @(negedge clk);
        rsp             = rsp_want && (inflight.size() > 0);
        jump_flag_i     = jmp;
        jump_addr_i     = ja;
        ifu_req_ready_i = rdy;
        inst_ready_i    = ird;
        ifu_rsp_valid_i = rsp;
        ifu_rsp_data_i  = rsp ? mem_word(inflight[0].addr) : $urandom;
        ifu_rsp_err_i   = er;
        #1;
        exp_rv = !m_halt && !jmp && (inflight.size() < MAXO)
               && (inflight.size() + fifo.size() < DEPTH);
        exp_iv = (fifo.size() > 0) && !jmp;
        check_eq("req_valid", 32'(ifu_req_valid_o), 32'(exp_rv));
        if (exp_rv) check_eq("req_addr", ifu_req_addr_o, m_pc);
        check_eq("inst_valid", 32'(inst_valid_o), 32'(exp_iv));
        if (exp_iv) begin
            check_eq("inst_pc", inst_pc_o, fifo[0].pc);
            check_eq("inst_data", inst_o, fifo[0].data);
            check_eq("inst_err", 32'(inst_err_o), 32'(fifo[0].err));
        end
        fire = exp_rv && rdy;
        pop  = exp_iv && ird;
        if (pop) void'(fifo.pop_front());
        if (rsp) begin
            e = inflight.pop_front();
            if (!e.stale && !jmp) begin
                ne.pc   = e.addr;
                ne.data = mem_word(e.addr);
                ne.err  = er;
                fifo.push_back(ne);
                if (er) m_halt = 1'b1;
            end
        end
        if (fire) begin
            e.addr  = m_pc;
            e.stale = 1'b0;
            inflight.push_back(e);
            m_pc = m_pc + 32'd4;
        end
        if (jmp) begin
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            fifo.delete();
            m_pc   = ja & ~32'h3;
            m_halt = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] ja;
        rst = 1'b1;
        drive_idle();
        do_reset();

        // Streaming fetch with immediate responses and a willing decoder.
        repeat (8) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
        // Decoder stalls: credit limit stops requests.
        repeat (6) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        // Two in flight, redirect without and then with a same-cycle response.
        cycle(1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0180, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (6) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
        // Fault halts fetch; redirect resumes it.
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (5) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
        // Wraparound and unaligned target.
        cycle(1'b1, 32'hFFFF_FFFB, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (6) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 32'h0000_0103, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            ja = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : ($urandom & 32'h0000_0FFF);
            cycle($urandom_range(0, 19) == 0, ja,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
